uart_tx: RTL and testbench

//  UART transmit serializer placed directly downstream of a param_fifo TX buffer.
//  - Pops one word from the FIFO whenever idle.
//  - Frames the word as start / data (LSB first) / [parity] / stop bits on txd.
//  - Bit timing comes from a runtime clock divider; back-to-back frames have no idle gap.
//

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: transmit FSM states and the line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; tick marks the last clk cycle of a bit.
// Written to be shared by the transmitter and a future receiver.
module uart_baud_cnt #(
  parameter int div_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [div_width-1:0] div,
  output logic                 tick
);

  logic [div_width-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= div;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer fed directly by a FIFO head (start/data LSB-first/[parity]/stop).
// Optional parity bit is built in when the macro UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int width     = 8,
  parameter int div_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [div_width-1:0] clk_div,
  input  logic                 stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_en,
  input  logic                 parity_odd,
`endif
  input  logic                 fifo_has_dat,
  input  logic [width-1:0]     fifo_rdata,
  output logic                 fifo_re,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(width + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(width - 1);

  uart_tx_state_t       state;
  logic [width-1:0]     shifter;
  logic [width-1:0]     shifter_nx;
  logic [div_width-1:0] div_q;
  logic                 stop2_q;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tick;
  logic                 last_stop_cycle;
  logic                 baud_load;
  logic [div_width-1:0] baud_div;
  logic                 use_parity;
  logic                 parity_bit;

`ifdef UART_TX_PARITY_EN
  logic parity_en_q;
  logic parity_q;

  // Parity is folded at pop time so the DATA state only has to shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
    end else if (fifo_re) begin
      parity_en_q <= parity_en;
      parity_q    <= (^fifo_rdata) ^ parity_odd;
    end
  end

  assign use_parity = parity_en_q;
  assign parity_bit = parity_q;
`else
  assign use_parity = 1'b0;
  assign parity_bit = UART_IDLE_LEVEL;
`endif

  // The pop happens in the final stop cycle too, which is what removes the idle gap.
  assign last_stop_cycle = (state == STOP) && tick && (bit_idx == IDX_W'(stop2_q));
  assign fifo_re         = ((state == IDLE) || last_stop_cycle) && fifo_has_dat && !rst;
  assign tx_done         = last_stop_cycle && !rst;
  assign busy            = (state != IDLE);

  // A new frame loads the live divider; later bits reload the latched copy.
  assign baud_load  = fifo_re || (tick && (state != IDLE));
  assign baud_div   = fifo_re ? clk_div : div_q;
  assign shifter_nx = shifter >> 1;

  uart_baud_cnt #(
    .div_width(div_width)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .load(baud_load),
    .div (baud_div),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= UART_IDLE_LEVEL;
      shifter <= '0;
      div_q   <= '0;
      stop2_q <= 1'b0;
      bit_idx <= '0;
    end else if (fifo_re) begin
      state   <= START;
      txd     <= ~UART_IDLE_LEVEL;
      shifter <= fifo_rdata;
      div_q   <= clk_div;
      stop2_q <= stop2;
      bit_idx <= '0;
    end else if (tick) begin
      case (state)
        START: begin
          state   <= DATA;
          txd     <= shifter[0];
          bit_idx <= '0;
        end
        DATA: begin
          shifter <= shifter_nx;
          if (bit_idx == LAST_DATA) begin
            bit_idx <= '0;
            if (use_parity) begin
              state <= PARITY;
              txd   <= parity_bit;
            end else begin
              state <= STOP;
              txd   <= UART_IDLE_LEVEL;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            txd     <= shifter_nx[0];
          end
        end
        PARITY: begin
          state   <= STOP;
          txd     <= UART_IDLE_LEVEL;
          bit_idx <= '0;
        end
        STOP: begin
          txd <= UART_IDLE_LEVEL;
          if (bit_idx == IDX_W'(stop2_q)) begin
            state   <= IDLE;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue-backed FIFO feeds the DUT and each frame is
// compared cycle by cycle against a waveform built from the framing rules.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clk_div = 16'd0;
  logic        stop2 = 1'b0;
  logic        fifo_has_dat = 1'b0;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_re;
  logic        txd;
  logic        busy;
  logic        tx_done;
`ifdef UART_TX_PARITY_EN
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];
  bit   exp_txd[$], exp_done[$], exp_busy[$], exp_re[$];
  logic obs_txd[$], obs_done[$], obs_busy[$], obs_re[$];
  string sig_name[4] = '{"txd", "tx_done", "busy", "fifo_re"};

  always #5 clk = ~clk;

  uart_tx dut (
    .clk         (clk),
    .rst         (rst),
    .clk_div     (clk_div),
    .stop2       (stop2),
`ifdef UART_TX_PARITY_EN
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
`endif
    .fifo_has_dat(fifo_has_dat),
    .fifo_rdata  (fifo_rdata),
    .fifo_re     (fifo_re),
    .txd         (txd),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  // Upstream FIFO model: pop seen at the negedge, applied just after the next posedge.
  initial begin
    bit re_n;
    forever begin
      @(negedge clk);
      re_n = fifo_re;
      @(posedge clk);
      #1;
      if (re_n && fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_has_dat = (fifo_q.size() != 0);
      fifo_rdata   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    exp_txd.delete(); exp_done.delete(); exp_busy.delete(); exp_re.delete();
  endfunction

  // One frame as a list of line levels, each held div+1 cycles; 'more' = next word queued.
  function automatic void add_frame(input logic [7:0] w, input int div, input bit s2,
                                    input bit pe, input bit po, input bit more);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (pe) bits.push_back((^w) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c <= div; c++) begin
        exp_txd.push_back(bits[k]);
        exp_done.push_back(1'b0);
        exp_busy.push_back(1'b1);
        exp_re.push_back(1'b0);
      end
    end
    exp_done[exp_done.size()-1] = 1'b1;
    exp_re[exp_re.size()-1]     = more;
  endfunction

  function automatic void pad(input int n);
    while (exp_txd.size() < n) begin
      exp_txd.push_back(1'b1);
      exp_done.push_back(1'b0);
      exp_busy.push_back(1'b0);
      exp_re.push_back(1'b0);
    end
  endfunction

  // Counts observed-vs-model disagreements for one signal; reports the first one.
  function automatic int diffs(input int sel, output int first, output logic got, output bit want);
    int n;
    n = 0; first = -1; got = 1'bx; want = 1'b0;
    for (int i = 0; i < obs_txd.size(); i++) begin
      logic o;
      bit   e;
      case (sel)
        0:       begin o = obs_txd[i];  e = exp_txd[i];  end
        1:       begin o = obs_done[i]; e = exp_done[i]; end
        2:       begin o = obs_busy[i]; e = exp_busy[i]; end
        default: begin o = obs_re[i];   e = exp_re[i];   end
      endcase
      if (o !== e) begin
        n++;
        if (first < 0) begin first = i; got = o; want = e; end
      end
    end
    return n;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < obs_done.size(); i++) if (obs_done[i] === 1'b1) return i + 1;
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
  endtask

  // Records outputs for n cycles after the pop cycle (index 0 = first cycle after the pop).
  task automatic capture(input int n, input int change_at, input logic [15:0] new_div,
                         input bit skip_wait, output bit timed_out);
    int k;
    timed_out = 1'b0;
    obs_txd.delete(); obs_done.delete(); obs_busy.delete(); obs_re.delete();
    if (!skip_wait) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (fifo_re !== 1'b1 && k < 300);
      if (fifo_re !== 1'b1) begin
        timed_out = 1'b1;
        return;
      end
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      obs_txd.push_back(txd);
      obs_done.push_back(tx_done);
      obs_busy.push_back(busy);
      obs_re.push_back(fifo_re);
      if (i == change_at) begin
        clk_div = new_div;
        stop2   = ~stop2;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy !== 1'b0 || fifo_q.size() != 0 || fifo_has_dat) && k < 1000);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, want 0", busy, k);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit to;
    int nd, fi;
    logic g;
    bit w;
    rst = 1'b1;
    push(8'h5A);
    repeat (3) @(negedge clk);
    total += 5;
    if (txd !== 1'b1)     begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    if (fifo_re !== 1'b0) begin bad++; $display("FAIL reset_fifo_re: got %b want 0 (has_dat=%b)", fifo_re, fifo_has_dat); end
    if (fifo_q.size() != 1) begin bad++; $display("FAIL reset_no_pop: fifo depth %0d want 1", fifo_q.size()); end
    @(posedge clk);
    #1 rst = 1'b0;
    clk_div = 16'd0;
    stop2   = 1'b0;
    @(negedge clk);
    total++;
    if (fifo_re !== 1'b1) begin bad++; $display("FAIL post_reset_pop: fifo_re got %b want 1", fifo_re); end
    model_clear();
    add_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    pad(13);
    capture(13, -1, 16'd0, 1'b1, to);
    for (int s = 0; s < 4; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL post_reset_%s: %0d wrong, first at cycle %0d got %b want %b", sig_name[s], nd, fi + 1, g, w); end
    end
  endtask

  task automatic test_frame_a5();
    bit to;
    int nd, fi;
    logic g;
    bit w;
    wait_idle();
    clk_div = 16'd3;
    stop2   = 1'b0;
    push(8'hA5);
    @(negedge clk);
    total++;
    if (fifo_re !== 1'b1 || fifo_has_dat !== 1'b1) begin
      bad++; $display("FAIL a5_latency: fifo_re got %b want 1 in has_dat cycle", fifo_re);
    end
    model_clear();
    add_frame(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    pad(48);
    capture(48, -1, 16'd0, 1'b1, to);
    for (int s = 0; s < 4; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL a5_%s: %0d wrong, first at cycle %0d got %b want %b", sig_name[s], nd, fi + 1, g, w); end
    end
    total++;
    if (first_done() !== 40) begin bad++; $display("FAIL a5_done_cycle: got %0d want 40", first_done()); end
  endtask

  task automatic test_random_frames();
    bit to;
    int nd, fi, div;
    logic g;
    bit w, s2;
    logic [7:0] word;
    for (int f = 0; f < 6; f++) begin
      wait_idle();
      word = 8'($urandom);
      div  = $urandom_range(0, 3);
      s2   = 1'($urandom_range(0, 1));
      clk_div = 16'(div);
      stop2   = s2;
      push(word);
      model_clear();
      add_frame(word, div, s2, 1'b0, 1'b0, 1'b0);
      pad(exp_txd.size() + 3);
      capture(exp_txd.size(), -1, 16'd0, 1'b0, to);
      total++;
      if (to) begin bad++; $display("FAIL rand_start: no fifo_re for word %h", word); continue; end
      for (int s = 0; s < 4; s++) begin
        nd = diffs(s, fi, g, w);
        total++;
        if (nd !== 0) begin bad++; $display("FAIL rand_%s: word %h div %0d stop2 %0d, %0d wrong, first at %0d got %b want %b", sig_name[s], word, div, s2, nd, fi + 1, g, w); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int nd, fi, pops, div;
    logic g;
    bit w, s2;
    logic [7:0] words[4];
    wait_idle();
    clk_div = 16'd0;
    stop2   = 1'b0;
    push(8'h00);
    push(8'hFF);
    model_clear();
    add_frame(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    pad(24);
    capture(24, -1, 16'd0, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL b2b_start: no fifo_re"); end
    for (int s = 0; s < 4; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL b2b_%s: %0d wrong, first at cycle %0d got %b want %b", sig_name[s], nd, fi + 1, g, w); end
    end
    pops = 1;
    foreach (obs_re[i]) if (obs_re[i] === 1'b1) pops++;
    total++;
    if (pops !== 2) begin bad++; $display("FAIL b2b_pop_count: got %0d want 2", pops); end

    wait_idle();
    div = $urandom_range(0, 2);
    s2  = 1'($urandom_range(0, 1));
    clk_div = 16'(div);
    stop2   = s2;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      words[i] = 8'($urandom);
      push(words[i]);
      add_frame(words[i], div, s2, 1'b0, 1'b0, i != 3);
    end
    pad(exp_txd.size() + 3);
    capture(exp_txd.size(), -1, 16'd0, 1'b0, to);
    for (int s = 0; s < 4; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL b2b_rand_%s: div %0d stop2 %0d, %0d wrong, first at %0d got %b want %b", sig_name[s], div, s2, nd, fi + 1, g, w); end
    end
  endtask

  task automatic test_stop2_div_change();
    bit to;
    int nd, fi;
    logic g;
    bit w;
    wait_idle();
    clk_div = 16'd1;
    stop2   = 1'b1;
    push(8'h01);
    model_clear();
    add_frame(8'h01, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    pad(25);
    capture(25, 6, 16'd9, 1'b0, to);
    for (int s = 0; s < 4; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL stop2_%s: %0d wrong, first at cycle %0d got %b want %b", sig_name[s], nd, fi + 1, g, w); end
    end
    total++;
    if (first_done() !== 22) begin bad++; $display("FAIL stop2_done_cycle: got %0d want 22", first_done()); end

    // The divider and stop2 written mid-frame apply to the next frame.
    wait_idle();
    push(8'h3C);
    model_clear();
    add_frame(8'h3C, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    pad(102);
    capture(102, -1, 16'd0, 1'b0, to);
    for (int s = 0; s < 2; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL newdiv_%s: %0d wrong, first at cycle %0d got %b want %b", sig_name[s], nd, fi + 1, g, w); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int nd, fi;
    logic g;
    bit w;
    wait_idle();
    clk_div = 16'd1;
    stop2   = 1'b0;
    push(8'hC3);
    push(8'h96);
    model_clear();
    add_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    capture(8, -1, 16'd0, 1'b0, to);
    nd = diffs(0, fi, g, w);
    total++;
    if (nd !== 0) begin bad++; $display("FAIL midrst_prefix_txd: %0d wrong, first at %0d got %b want %b", nd, fi + 1, g, w); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total += 5;
    if (txd !== 1'b1)       begin bad++; $display("FAIL midrst_txd: got %b want 1", txd); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (fifo_re !== 1'b0)   begin bad++; $display("FAIL midrst_fifo_re: got %b want 0", fifo_re); end
    if (tx_done !== 1'b0)   begin bad++; $display("FAIL midrst_tx_done: got %b want 0", tx_done); end
    if (fifo_q.size() != 1) begin bad++; $display("FAIL midrst_depth: got %0d want 1", fifo_q.size()); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    add_frame(8'h96, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    pad(22);
    capture(22, -1, 16'd0, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL midrst_restart: no fifo_re after reset"); end
    for (int s = 0; s < 4; s++) begin
      nd = diffs(s, fi, g, w);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL midrst_next_%s: %0d wrong, first at %0d got %b want %b", sig_name[s], nd, fi + 1, g, w); end
    end
  endtask

  task automatic test_empty_fifo();
    int pops, lows, busies;
    wait_idle();
    pops = 0; lows = 0; busies = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_re === 1'b1) pops++;
      if (txd !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
      clk_div = 16'($urandom_range(0, 7));
      stop2   = 1'($urandom_range(0, 1));
    end
    total += 3;
    if (pops !== 0)   begin bad++; $display("FAIL empty_fifo_re: %0d pops want 0", pops); end
    if (lows !== 0)   begin bad++; $display("FAIL empty_txd: %0d cycles not high want 0", lows); end
    if (busies !== 0) begin bad++; $display("FAIL empty_busy: %0d busy cycles want 0", busies); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    int nd, fi;
    logic g;
    bit w;
    for (int odd = 0; odd < 2; odd++) begin
      wait_idle();
      clk_div    = 16'd0;
      stop2      = 1'b0;
      parity_en  = 1'b1;
      parity_odd = 1'(odd);
      push(8'h07);
      model_clear();
      add_frame(8'h07, 0, 1'b0, 1'b1, 1'(odd), 1'b0);
      pad(14);
      capture(14, -1, 16'd0, 1'b0, to);
      for (int s = 0; s < 4; s++) begin
        nd = diffs(s, fi, g, w);
        total++;
        if (nd !== 0) begin bad++; $display("FAIL parity%0d_%s: %0d wrong, first at %0d got %b want %b", odd, sig_name[s], nd, fi + 1, g, w); end
      end
      total += 2;
      if (obs_txd[9] !== 1'(1 - odd)) begin bad++; $display("FAIL parity%0d_bit: got %b want %0d", odd, obs_txd[9], 1 - odd); end
      if (first_done() !== 11) begin bad++; $display("FAIL parity%0d_len: done at %0d want 11", odd, first_done()); end
    end
    parity_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame_a5();
    test_random_frames();
    test_back_to_back();
    test_stop2_div_change();
    test_reset_mid_frame();
    test_empty_fifo();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
